// File: rtl/float_to_fixed_stage_if.sv
// Operand/result bundle for the float-to-fixed converter: one float in, one
// fixed-point result with overflow/NaN flags out.
interface float_to_fixed_stage_if #(
    parameter int OUT_WIDTH = 32
);
    logic                 in_valid;
    logic [31:0]          in_data;
    logic                 out_valid;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_overflow;
    logic                 out_nan;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_data, out_overflow, out_nan
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_data, out_overflow, out_nan
    );
endinterface

// File: rtl/float_to_fixed_stage.sv
// Three-stage IEEE-754 single to signed fixed-point converter (unpack, align, sign/saturate).
// Define FLOAT_TO_FIXED_ROUND_EN for round-half-away-from-zero instead of truncation.
module float_to_fixed_stage #(
    parameter int OUT_WIDTH = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    float_to_fixed_stage_if.slave   bus
);
`ifdef FLOAT_TO_FIXED_ROUND_EN
    localparam int GB = 1;
`else
    localparam int GB = 0;
`endif
    localparam int WW = OUT_WIDTH + 25;
    localparam logic signed [11:0] SH_BIAS = 12'(FRAC_BITS + GB - 23);
    localparam logic [WW-1:0] LIM = {{(WW-OUT_WIDTH){1'b0}}, 1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] POS_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] NEG_MAX = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic               r_s1_valid, r_s1_sign, r_s1_zero, r_s1_nan, r_s1_inf;
    logic signed [9:0]  r_s1_exp;
    logic [23:0]        r_s1_sig;

    logic                 r_s2_valid, r_s2_sign, r_s2_ovf, r_s2_nan;
    logic [OUT_WIDTH-1:0] r_s2_mag;

    logic                 r_out_valid, r_out_ovf, r_out_nan;
    logic [OUT_WIDTH-1:0] r_out_data;

    logic signed [11:0]   w_sh;
    logic [11:0]          w_amt;
    logic [WW-1:0]        w_wide, w_mag;
    logic                 w_huge, w_ovf;
    logic [OUT_WIDTH-1:0] w_res;

    // Stage 1: unpack the float and classify zero/denormal, NaN and Inf.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_nan   <= 1'b0;
            r_s1_inf   <= 1'b0;
            r_s1_exp   <= 10'sd0;
            r_s1_sig   <= 24'd0;
        end else if (clk_en) begin
            r_s1_valid <= bus.in_valid;
            r_s1_sign  <= bus.in_data[31];
            r_s1_exp   <= {2'b00, bus.in_data[30:23]} - 10'd127;
            r_s1_sig   <= {1'b1, bus.in_data[22:0]};
            r_s1_zero  <= (bus.in_data[30:23] == 8'd0);
            r_s1_nan   <= (bus.in_data[30:23] == 8'hFF) && (bus.in_data[22:0] != 23'd0);
            r_s1_inf   <= (bus.in_data[30:23] == 8'hFF) && (bus.in_data[22:0] == 23'd0);
        end
    end

    // Stage 2 datapath: shift the significand into place and judge the range.
    // Left shifts past OUT_WIDTH are saturating anyway, so they never reach the shifter.
    always_comb begin
        w_sh   = {{2{r_s1_exp[9]}}, r_s1_exp} + SH_BIAS;
        w_amt  = 12'd0;
        w_wide = {WW{1'b0}};
        w_huge = 1'b0;
        if (w_sh >= 12'sd0) begin
            w_amt = w_sh;
            if (w_amt > 12'(OUT_WIDTH)) begin
                w_huge = 1'b1;
            end else begin
                w_wide = {{(WW-24){1'b0}}, r_s1_sig} << w_amt;
            end
        end else begin
            w_amt = 12'(-w_sh);
            if (w_amt >= 12'd24) begin
                w_wide = {WW{1'b0}};
            end else begin
                w_wide = {{(WW-24){1'b0}}, r_s1_sig} >> w_amt;
            end
        end
`ifdef FLOAT_TO_FIXED_ROUND_EN
        w_mag = (w_wide >> 1) + {{(WW-1){1'b0}}, w_wide[0]};
`else
        w_mag = w_wide;
`endif
        w_ovf = w_huge || (w_mag > LIM) || ((w_mag == LIM) && !r_s1_sign);
    end

    // Stage 2 registers: magnitude plus saturate/NaN decisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_ovf   <= 1'b0;
            r_s2_nan   <= 1'b0;
            r_s2_mag   <= {OUT_WIDTH{1'b0}};
        end else if (clk_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_nan   <= r_s1_nan;
            r_s2_ovf   <= r_s1_inf || (!r_s1_zero && !r_s1_nan && w_ovf);
            r_s2_mag   <= (r_s1_zero || r_s1_nan || r_s1_inf || w_ovf) ?
                          {OUT_WIDTH{1'b0}} : w_mag[OUT_WIDTH-1:0];
        end
    end

    // Stage 3 datapath: apply sign or substitute the saturated / NaN result.
    always_comb begin
        if (r_s2_nan) begin
            w_res = {OUT_WIDTH{1'b0}};
        end else if (r_s2_ovf) begin
            w_res = r_s2_sign ? NEG_MAX : POS_MAX;
        end else if (r_s2_sign) begin
            w_res = {OUT_WIDTH{1'b0}} - r_s2_mag;
        end else begin
            w_res = r_s2_mag;
        end
    end

    // Output registers; flags are forced low on bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {OUT_WIDTH{1'b0}};
            r_out_ovf   <= 1'b0;
            r_out_nan   <= 1'b0;
        end else if (clk_en) begin
            r_out_valid <= r_s2_valid;
            r_out_data  <= r_s2_valid ? w_res : {OUT_WIDTH{1'b0}};
            r_out_ovf   <= r_s2_valid && r_s2_ovf && !r_s2_nan;
            r_out_nan   <= r_s2_valid && r_s2_nan;
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.out_overflow = r_out_ovf;
    assign bus.out_nan      = r_out_nan;
endmodule

// File: tb/tb_float_to_fixed_stage.sv
// Bench for float_to_fixed_stage: real-arithmetic reference model behind a
// three-enabled-edge delay line, directed literal cases, then randomized traffic.
module tb_float_to_fixed_stage;
    localparam int OW = 32;
    localparam int FRAC = 16;

    typedef struct packed {
        logic        ovf;
        logic        nan;
        logic [31:0] data;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b1;
    int   nvec = 0;
    int   nfail = 0;

    float_to_fixed_stage_if #(.OUT_WIDTH(OW)) bus ();

    float_to_fixed_stage #(.OUT_WIDTH(OW), .FRAC_BITS(FRAC)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference: value = significand * 2^(e-23+FRAC), truncated or rounded, then range-checked.
    function automatic res_t model(input logic [31:0] f);
        res_t   r;
        real    m;
        longint mag;
        int     e;
        r = '0;
        e = int'(f[30:23]);
        if (e == 0) begin
            r.data = 32'h0;
        end else if (e == 255) begin
            if (f[22:0] != 23'd0) begin
                r.nan = 1'b1;
            end else begin
                r.ovf  = 1'b1;
                r.data = f[31] ? 32'h80000000 : 32'h7FFFFFFF;
            end
        end else begin
            m = real'(int'({1'b1, f[22:0]})) * (2.0 ** (e - 127 - 23 + FRAC));
`ifdef FLOAT_TO_FIXED_ROUND_EN
            m = $floor(m + 0.5);
`else
            m = $floor(m);
`endif
            if (m > 2.0 ** 31 || (m == 2.0 ** 31 && !f[31])) begin
                r.ovf  = 1'b1;
                r.data = f[31] ? 32'h80000000 : 32'h7FFFFFFF;
            end else begin
                mag    = longint'(m);
                r.data = f[31] ? 32'(-mag) : 32'(mag);
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    logic pv [3];
    res_t pr [3];

    // Expected results travel a three-deep line that only moves on enabled edges.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) pv[i] <= 1'b0;
        end else if (clk_en) begin
            pv[0] <= bus.in_valid;
            pr[0] <= model(bus.in_data);
            pv[1] <= pv[0];
            pr[1] <= pr[0];
            pv[2] <= pv[1];
            pr[2] <= pr[1];
        end
    end

    always @(negedge clk) begin
        chk("m_valid", 32'(bus.out_valid), 32'(pv[2]));
        if (pv[2]) begin
            chk("m_data", bus.out_data, pr[2].data);
            chk("m_ovf", 32'(bus.out_overflow), 32'(pr[2].ovf));
            chk("m_nan", 32'(bus.out_nan), 32'(pr[2].nan));
        end else begin
            chk("m_idle_flags", {30'd0, bus.out_overflow, bus.out_nan}, 32'd0);
        end
    end

    task automatic send(input logic [31:0] f);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = f;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_out(input string nm, input logic [31:0] d, input logic o, input logic n);
        chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({nm, "_data"}, bus.out_data, d);
        chk({nm, "_ovf"}, 32'(bus.out_overflow), 32'(o));
        chk({nm, "_nan"}, 32'(bus.out_nan), 32'(n));
    endtask

    task automatic one(input logic [31:0] f, input logic [31:0] d, input logic o,
                       input logic n, input string nm);
        send(f);
        idle();
        idle();
        @(negedge clk);
        check_out(nm, d, o, n);
        repeat (2) idle();
    endtask

    function automatic logic [31:0] rand_float();
        logic [31:0] f;
        f = $urandom;
        case ($urandom_range(0, 7))
            0, 1:    f = f;
            2:       f[30:23] = 8'd0;
            3:       f[30:23] = 8'hFF;
            default: f[30:23] = 8'($urandom_range(100, 160));
        endcase
        return f;
    endfunction

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_data", bus.out_data, 32'd0);
        chk("reset_flags", {30'd0, bus.out_overflow, bus.out_nan}, 32'd0);
        rst = 1'b0;

        one(32'h40A00000, 32'h00050000, 1'b0, 1'b0, "five");
        one(32'h47800000, 32'h7FFFFFFF, 1'b1, 1'b0, "pos_ovf");
        one(32'hC7000000, 32'h80000000, 1'b0, 1'b0, "most_neg");
        one(32'hFF800000, 32'h80000000, 1'b1, 1'b0, "neg_inf");
        one(32'h7FC00000, 32'h00000000, 1'b0, 1'b1, "nan");
        one(32'h80000000, 32'h00000000, 1'b0, 1'b0, "neg_zero");
        one(32'h00000001, 32'h00000000, 1'b0, 1'b0, "denormal");
`ifdef FLOAT_TO_FIXED_ROUND_EN
        one(32'h37000000, 32'h00000001, 1'b0, 1'b0, "tiny");
`else
        one(32'h37000000, 32'h00000000, 1'b0, 1'b0, "tiny");
`endif

        send(32'h43340000);
        send(32'hC2700000);
        send(32'h40200000);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_out("b2b_0", 32'h00B40000, 1'b0, 1'b0);
        @(negedge clk);
        check_out("b2b_1", 32'hFFC40000, 1'b0, 1'b0);
        @(negedge clk);
        check_out("b2b_2", 32'h00028000, 1'b0, 1'b0);
        repeat (2) idle();

        // Stall for four edges after the operand is captured.
        send(32'h40A00000);
        repeat (4) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            clk_en = 1'b0;
            chk("stall_valid", 32'(bus.out_valid), 32'd0);
        end
        @(negedge clk);
        clk_en = 1'b1;
        @(negedge clk);
        chk("stall_early", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check_out("stall_out", 32'h00050000, 1'b0, 1'b0);
        repeat (2) idle();

        // Reset with two operands in flight.
        send(32'h40A00000);
        send(32'h43340000);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("flush_valid", 32'(bus.out_valid), 32'd0);
        end

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst          = ($urandom_range(0, 299) == 0);
            clk_en       = ($urandom_range(0, 9) != 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = rand_float();
        end
        @(negedge clk);
        rst = 1'b0;
        clk_en = 1'b1;
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/float_to_fixed_stage.md
Name: float_to_fixed_stage

Overview:
- Pipelined IEEE-754 single-precision to signed fixed-point converter.
- Sits directly upstream of function_evaluation's CORDIC datapath. It turns the float operands delivered on the custom-instruction dataa/datab buses into the two's-complement fixed-point format the iteration stages consume.
- Three register stages, one result per enabled clock.
- Flags overflow and NaN so the controller can report them.

Parameters:
- OUT_WIDTH, 32, total width of the signed fixed-point output.
- FRAC_BITS, 16, number of fractional bits in the output (output LSB = 2^-FRAC_BITS).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- clk_en  input  1  global pipeline enable; when low, no register in the block changes.
- in_valid  input  1  in_data holds an operand to convert this cycle.
- in_data  input  32  IEEE-754 single: [31] sign, [30:23] exponent, [22:0] mantissa.
- out_valid  output  1  out_data/flags valid this cycle.
- out_data  output  OUT_WIDTH  signed two's-complement result, FRAC_BITS fractional bits.
- out_overflow  output  1  result saturated (magnitude out of range, or ±Inf).
- out_nan  output  1  input was NaN.

Behaviour:
- Reset: when rst=1 at a rising edge, all stage valids and all outputs clear to 0 (out_valid=0, out_data=0, out_overflow=0, out_nan=0), regardless of clk_en. Reset mid-conversion discards in-flight data; no partial output appears afterwards.
- Enable: when clk_en=0, every stage holds its contents, including valid bits. Latency is exactly 3 clk_en-high edges from the edge sampling in_valid=1 to out_valid=1.
- Throughput: one operand per enabled cycle, no backpressure. Back-to-back inputs produce back-to-back outputs in order.
- in_valid=0 inserts a bubble. The stage valid propagates as 0; data registers may hold anything, but flags are qualified by out_valid.
- Outputs with out_valid=0 must hold 0 on out_overflow/out_nan.
- Stage 1, unpack/classify:
  - Latch the sign, unbiased exponent e = exp-127, and significand {1,mant}.
  - Classify the operand:
    - exp=0 (zero or denormal): treat as zero.
    - exp=255 with mant≠0: NaN.
    - exp=255 with mant=0: Inf.
- Stage 2, align:
  - Magnitude = significand shifted so the value = significand·2^(e-23+FRAC_BITS).
  - Left shift when the exponent of that product is ≥0, else right shift; right-shifted-out bits are discarded.
  - Compute a range flag: overflow if magnitude ≥ 2^(OUT_WIDTH-1), except the exact case sign=1 with magnitude = 2^(OUT_WIDTH-1), which is legal (most-negative value).
  - Shift amounts ≥ OUT_WIDTH+24 produce the saturate/zero result without undefined shifts.
- Stage 3, sign/saturate:
  - Result is negated if sign=1.
  - Overflow or Inf: out_data = 0x7FF..F (positive) or 0x800..0 (negative), and out_overflow=1.
  - NaN: out_data=0, out_nan=1, out_overflow=0.
  - Zero/denormal: out_data=0 for both +0 and -0.
- Rounding (default): truncation of magnitude, i.e. toward zero.

Optional Feature:
- Macro FLOAT_TO_FIXED_ROUND_EN.
- Defined: stage 2 keeps one guard bit below the output LSB and adds it to the magnitude (round half away from zero). A carry out of range is treated as overflow and saturates, setting out_overflow.
- Undefined: pure truncation toward zero; no guard-bit logic.
- Latency is 3 in both builds.

Test Plan:
- Reset then convert 0x40A00000 (5.0) with clk_en=1 -> 3 edges later out_valid=1, out_data=0x00050000, flags 0.
- Back-to-back 0x43340000 (180.0), 0xC2700000 (-60.0), 0x40200000 (2.5) -> consecutive outputs 0x00B40000, 0xFFC40000, 0x00028000.
- 0x47800000 (65536.0) -> 0x7FFFFFFF, out_overflow=1. 0xC7000000 (-32768.0) -> 0x80000000, out_overflow=0. 0xFF800000 (-Inf) -> 0x80000000, out_overflow=1.
- 0x7FC00000 (NaN) -> out_data=0, out_nan=1. 0x80000000 (-0) and 0x00000001 (denormal) -> 0, flags 0.
- 0x37000000 (2^-17) -> 0x00000000 without macro; 0x00000001 with FLOAT_TO_FIXED_ROUND_EN.
- Feed 5.0, drop clk_en for 4 cycles after the first edge, then raise it -> output appears after exactly 3 enabled edges with unchanged value. Assert rst with 2 items in flight -> no out_valid afterwards until new input.
